// File: rtl/nn_pkg.sv
// Shared definitions for the neuron blocks: FSM states, accumulator sizing and
// the default fixed-point format used by hidden and output layers.
package nn_pkg;

  localparam int DEF_DW   = 10;
  localparam int DEF_FRAC = 6;
  localparam int DEF_N_IN = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    PREP = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Full-precision dot product plus shifted bias never overflows this width.
  function automatic int acc_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in + 1) + 1;
  endfunction

endpackage

// File: rtl/neuron_softsign_div.sv
// Restoring divider producing q = floor(nn * 2^DW / d) MSB first, one bit per
// cycle; requires nn < d so the quotient fits in DW bits.
module neuron_softsign_div #(
  parameter int DW = 10,
  parameter int OW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [OW-1:0] nn,
  input  logic [OW-1:0] d,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q
);

  localparam int IW = $clog2(DW + 1);

  logic [OW-1:0] r_reg;
  logic [OW-1:0] d_reg;
  logic [DW-2:0] q_reg;
  logic [IW-1:0] iter_reg;
  logic          busy_reg;

  logic [OW:0]   r2;
  logic          ge;
  logic [OW-1:0] r_next;
  logic [DW-1:0] q_full;

  // The remainder stays below d, so the subtracted value always fits in OW bits.
  assign r2     = {r_reg, 1'b0};
  assign ge     = (r2 >= {1'b0, d_reg});
  assign r_next = ge ? (r2[OW-1:0] - d_reg) : r2[OW-1:0];
  assign q_full = {q_reg, ge};

  // done flags the cycle whose edge retires the final quotient bit; q is then final.
  assign busy = busy_reg;
  assign done = busy_reg && (iter_reg == IW'(DW - 1));
  assign q    = q_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg    <= '0;
      d_reg    <= '0;
      q_reg    <= '0;
      iter_reg <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      r_reg    <= nn;
      d_reg    <= d;
      q_reg    <= '0;
      iter_reg <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      r_reg    <= r_next;
      q_reg    <= q_full[DW-2:0];
      iter_reg <= iter_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_hidden_neuron.sv
// Time-multiplexed hidden neuron: one MAC per accepted pair, then the softsign
// activation 0.5*(X/(1+|X|)+1) through an iterative divider.
module mac_hidden_neuron
  import nn_pkg::*;
#(
  parameter int N_IN = DEF_N_IN,
  parameter int DW   = DEF_DW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_val,
  input  logic signed [DW-1:0] weight,
  input  logic signed [DW-1:0] bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_val
);

  localparam int ACC_W = acc_width(DW, N_IN);
  localparam int OW    = ACC_W + 2;
  localparam int CW    = $clog2(N_IN + 1);
  localparam logic [OW-1:0] ONE = OW'(1) << (2 * FRAC);

  state_t                  state_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [CW-1:0]           beat_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic [DW-1:0]           out_val_reg;

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] bias_ext;
  logic             accept;
  logic             acc_neg;
  logic [ACC_W:0]   acc_x;
  logic [ACC_W:0]   abs_a;
  logic [OW-1:0]    a_ext;
  logic [OW-1:0]    div_nn;
  logic [OW-1:0]    div_d;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DW-1:0]    div_q;

  // Operands sign-extended to 2*DW so the truncated product is the exact signed result.
  assign prod     = {{DW{in_val[DW-1]}}, in_val} * {{DW{weight[DW-1]}}, weight};
  assign prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(ACC_W - DW - FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
  assign accept   = in_valid && in_ready_reg;

  // |acc| in one extra bit keeps the most-negative accumulator representable.
  assign acc_neg = acc_reg[ACC_W-1];
  assign acc_x   = {acc_reg[ACC_W-1], acc_reg};
  assign abs_a   = acc_neg ? -acc_x : acc_x;
  assign a_ext   = {1'b0, abs_a};
  assign div_d   = (ONE + a_ext) << 1;
  assign div_nn  = acc_neg ? ONE : (ONE + (a_ext << 1));

  assign div_start = (state_reg == PREP);

  neuron_softsign_div #(
    .DW (DW),
    .OW (OW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .nn    (div_nn),
    .d     (div_d),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      beat_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_val_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg  <= bias_ext + prod_ext;
            beat_reg <= CW'(1);
            if (N_IN == 1) begin
              state_reg    <= PREP;
              in_ready_reg <= 1'b0;
            end else begin
              state_reg <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_reg  <= acc_reg + prod_ext;
            beat_reg <= beat_reg + 1'b1;
            if (beat_reg == CW'(N_IN - 1)) begin
              state_reg    <= PREP;
              in_ready_reg <= 1'b0;
            end
          end
        end
        PREP: begin
          state_reg <= DIV;
        end
        DIV: begin
          if (div_busy && div_done) begin
            out_val_reg   <= div_q;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            beat_reg      <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_val   = out_val_reg;

endmodule

// File: tb/tb_mac_hidden_neuron.sv
// Bench for mac_hidden_neuron: default configuration directed/random scenarios plus
// a wide configuration (N_IN=16, DW=12, FRAC=8) checked against an arithmetic model.
module tb_mac_hidden_neuron;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default configuration
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [9:0] in_val = '0;
  logic signed [9:0] weight = '0;
  logic signed [9:0] bias = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [9:0]        out_val;

  // wide configuration
  logic               b_in_valid = 1'b0;
  logic               b_in_ready;
  logic signed [11:0] b_in_val = '0;
  logic signed [11:0] b_weight = '0;
  logic signed [11:0] b_bias = '0;
  logic               b_out_valid;
  logic               b_out_ready = 1'b0;
  logic [11:0]        b_out_val;

  mac_hidden_neuron dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .weight(weight), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val)
  );

  mac_hidden_neuron #(.N_IN(16), .DW(12), .FRAC(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_val(b_in_val), .weight(b_weight), .bias(b_bias),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_val(b_out_val)
  );

  int n_vec = 0;
  int n_err = 0;
  int vx[16];
  int vw[16];
  int vb;

  // X = bias*2^FRAC + sum(x*w); out = floor(Nn*2^DW / D)
  function automatic longint ref_q(input int dw, input int frac, input int n, input int b,
                                   input int xs[16], input int ws[16]);
    longint x, a, one, d, nn;
    x = longint'(b) * (longint'(1) << frac);
    for (int i = 0; i < n; i++) x += longint'(xs[i]) * longint'(ws[i]);
    a   = (x < 0) ? -x : x;
    one = longint'(1) << (2 * frac);
    d   = 2 * (one + a);
    nn  = (x >= 0) ? (one + 2 * a) : one;
    return (nn * (longint'(1) << dw)) / d;
  endfunction

  function automatic int rnd_s(input int w);
    return int'($urandom_range((1 << w) - 1)) - (1 << (w - 1));
  endfunction

  task automatic fill_random(input int w, input int n);
    for (int i = 0; i < 16; i++) begin
      vx[i] = (i < n) ? rnd_s(w) : 0;
      vw[i] = (i < n) ? rnd_s(w) : 0;
    end
    vb = rnd_s(w);
  endtask

  task automatic fill_const(input int x0, input int w0, input int xr, input int wr, input int b);
    for (int i = 0; i < 16; i++) begin
      vx[i] = (i == 0) ? x0 : xr;
      vw[i] = (i == 0) ? w0 : wr;
    end
    vb = b;
  endtask

  // Presents n pairs; returns #1 after the edge that accepted the last one.
  // Bias carries junk after the first beat since it must be ignored then.
  task automatic drive_pairs(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_val   = vx[i][9:0];
      weight   = vw[i][9:0];
      bias     = (i == 0) ? vb[9:0] : 10'($urandom_range(1023));
      for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, output int q, output int lat, output bit to,
                             output bit stable_ok, output bit ready_ok);
    lat = 0; to = 1'b0; stable_ok = 1'b1; ready_ok = 1'b1; q = 0;
    while (!out_valid && !to) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) ready_ok = 1'b0;
      if (lat > 100) to = 1'b1;
    end
    if (!to) begin
      q = int'(out_val);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (!out_valid || int'(out_val) != q) stable_ok = 1'b0;
        if (in_ready) ready_ok = 1'b0;
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic run_b(output int q, output bit to);
    int lat;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2 && $urandom_range(3) == 0; g++) begin
        b_in_valid = 1'b0;
        @(negedge clk);
      end
      b_in_valid = 1'b1;
      b_in_val   = vx[i][11:0];
      b_weight   = vw[i][11:0];
      b_bias     = (i == 0) ? vb[11:0] : 12'($urandom_range(4095));
      for (int k = 0; k < 50 && !b_in_ready; k++) @(negedge clk);
      @(posedge clk);
    end
    #1 b_in_valid = 1'b0;
    lat = 0; to = 1'b0; q = 0;
    while (!b_out_valid && !to) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 100) to = 1'b1;
    end
    if (!to) begin
      q = int'(b_out_val);
      repeat ($urandom_range(2)) @(posedge clk);
      @(negedge clk); b_out_ready = 1'b1;
      @(posedge clk); #1; b_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    n_vec += 3;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_val !== 10'd0) begin n_err++; $display("FAIL reset_out_val got %0d want 0", out_val); end
    $display("reset: in_ready=%b out_valid=%b out_val=%0d", in_ready, out_valid, out_val);
  endtask

  task automatic test_zero;
    int q, lat; bit to, st, rd;
    fill_const(0, 0, 0, 0, 0);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    n_vec += 5;
    if (to) begin n_err++; $display("FAIL zero_timeout got timeout want out_valid"); end
    if (q != 512) begin n_err++; $display("FAIL zero_out_val got %0d want 512", q); end
    if (lat != 11) begin n_err++; $display("FAIL zero_latency got %0d want 11", lat); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_post_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_post_ready got %b want 1", in_ready); end
    $display("zero sample: out_val=%0d latency=%0d", q, lat);
  endtask

  task automatic test_unit;
    int q, lat; bit to, st, rd;
    fill_const(64, 64, 0, 0, 0);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    n_vec++;
    if (to || q != 768) begin n_err++; $display("FAIL unit_pos got %0d want 768", q); end
    $display("unit +1.0*+1.0: out_val=%0d", q);
    fill_const(64, -64, 0, 0, 0);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    n_vec++;
    if (to || q != 256) begin n_err++; $display("FAIL unit_neg got %0d want 256", q); end
    $display("unit +1.0*-1.0: out_val=%0d", q);
  endtask

  task automatic test_extremes;
    int q, lat; bit to, st, rd;
    fill_const(511, 511, 511, 511, 511);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    n_vec++;
    if (to || q != 1023) begin n_err++; $display("FAIL max_pos got %0d want 1023", q); end
    $display("max positive: out_val=%0d", q);
    fill_const(511, -512, 511, -512, -512);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    n_vec++;
    if (to || q != 0) begin n_err++; $display("FAIL max_neg got %0d want 0", q); end
    $display("max negative: out_val=%0d", q);
  endtask

  task automatic test_stall;
    int q1, q2, lat; bit to, st, rd;
    longint exp_q;
    fill_random(10, 10);
    exp_q = ref_q(10, 6, 10, vb, vx, vw);
    drive_pairs(10, 1'b0);
    wait_result(0, q1, lat, to, st, rd);
    drive_pairs(10, 1'b1);
    wait_result(20, q2, lat, to, st, rd);
    n_vec += 4;
    if (longint'(q1) != exp_q) begin n_err++; $display("FAIL stall_gapfree got %0d want %0d", q1, exp_q); end
    if (to || longint'(q2) != exp_q) begin n_err++; $display("FAIL stall_gapped got %0d want %0d", q2, exp_q); end
    if (!st) begin n_err++; $display("FAIL stall_stable got unstable want stable"); end
    if (!rd) begin n_err++; $display("FAIL stall_in_ready got 1 while busy want 0"); end
    $display("stall: gapfree=%0d gapped=%0d expected=%0d", q1, q2, exp_q);
  endtask

  task automatic test_reset_mid;
    int q, lat; bit to, st, rd;
    longint exp_q;
    // abort in ACC after five beats
    fill_random(10, 10);
    drive_pairs(5, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    n_vec += 3;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== 10'd0) begin
      n_err++; $display("FAIL rst_acc got ready=%b valid=%b val=%0d want 1 0 0", in_ready, out_valid, out_val);
    end
    @(negedge clk); rst = 1'b0;
    fill_random(10, 10);
    exp_q = ref_q(10, 6, 10, vb, vx, vw);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    if (to || longint'(q) != exp_q) begin n_err++; $display("FAIL rst_acc_next got %0d want %0d", q, exp_q); end
    // abort in DIV at iteration 4 (PREP edge plus four division edges)
    fill_random(10, 10);
    drive_pairs(10, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== 10'd0) begin
      n_err++; $display("FAIL rst_div got ready=%b valid=%b val=%0d want 1 0 0", in_ready, out_valid, out_val);
    end
    @(negedge clk); rst = 1'b0;
    fill_random(10, 10);
    exp_q = ref_q(10, 6, 10, vb, vx, vw);
    drive_pairs(10, 1'b0);
    wait_result(0, q, lat, to, st, rd);
    n_vec++;
    if (to || longint'(q) != exp_q) begin n_err++; $display("FAIL rst_div_next got %0d want %0d", q, exp_q); end
    $display("reset mid-sample: recovered out_val=%0d expected=%0d", q, exp_q);
  endtask

  task automatic test_back_to_back;
    int q, lat; bit to, st, rd;
    longint exp_q;
    for (int s = 0; s < 20; s++) begin
      fill_random(10, 10);
      exp_q = ref_q(10, 6, 10, vb, vx, vw);
      drive_pairs(10, s[0]);
      wait_result(int'($urandom_range(3)), q, lat, to, st, rd);
      n_vec++;
      if (to || longint'(q) != exp_q || !st || !rd) begin
        n_err++; $display("FAIL b2b_%0d got %0d want %0d (stable=%b ready_ok=%b)", s, q, exp_q, st, rd);
      end
      $display("b2b %0d: out_val=%0d expected=%0d", s, q, exp_q);
    end
  endtask

  task automatic test_random_wide;
    int q; bit to;
    longint exp_q;
    for (int s = 0; s < 1000; s++) begin
      fill_random(12, 16);
      if (s == 0) fill_const(0, 0, 0, 0, 0);
      exp_q = ref_q(12, 8, 16, vb, vx, vw);
      run_b(q, to);
      n_vec++;
      if (to || longint'(q) != exp_q) begin
        n_err++; $display("FAIL wide_%0d got %0d want %0d", s, q, exp_q);
      end
      $display("wide %0d: out_val=%0d expected=%0d", s, q, exp_q);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_unit();
    test_extremes();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
